hex_display_scheduler: RTL and testbench

- Shares the 8-digit DE2 hex display between up to NUM_SRC requesters (programmer address, data, status, error code, and so on).
- Grants the display to one valid source at a time, in round-robin order, with a fixed dwell time per source.
- While a source owns the display, its live 32-bit value is passed through.
- Drives hex_data of DE2_hex_driver; user keys/switches supply manual advance and freeze.

---
 rtl/hex_sched_pkg.sv | 18 +
 rtl/hex_rr_pick.sv | 34 +++
 rtl/hex_display_scheduler.sv | 125 ++++++++++++
 tb/tb_hex_display_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_sched_pkg.sv
// Shared types and constants for the DE2 hex display scheduler.
package hex_sched_pkg;

  localparam int DIGIT_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_t;

  // The dwell counter never holds a value above DWELL_CYCLES-1, so $clog2 suffices.
  function automatic int dwell_cnt_width(input int dwell_cycles);
    int w;
    w = $clog2(dwell_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_rr_pick.sv
// Combinational round-robin finder: returns the first valid index after 'start',
// wrapping around, with 'start' itself considered last (or never when excluded).
module hex_rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         valid,
  input  logic [$clog2(NUM_SRC)-1:0] start,
  input  logic                       exclude_start,
  output logic                       found,
  output logic [$clog2(NUM_SRC)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_SRC);

  always_comb begin : pick_search
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    index    = start;
    // Offset NUM_SRC lands back on 'start', which is why it is tried last.
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(start) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!found && valid[cand_idx] && !(k == NUM_SRC && exclude_start)) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-shares the 8-digit hex display between several 32-bit sources in
// round-robin order with a fixed dwell per source, plus manual advance/freeze.
module hex_display_scheduler
  import hex_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [DIGIT_DATA_W*NUM_SRC-1:0]   src_data,
  input  logic                              advance,
  input  logic                              freeze,
  output logic [DIGIT_DATA_W-1:0]           hex_data,
  output logic [$clog2(NUM_SRC)-1:0]        cur_src,
  output logic                              active,
  output logic                              switched
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = dwell_cnt_width(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t state, state_n;
  logic [CNT_W-1:0]        dwell_cnt, dwell_cnt_n;
  logic [IDX_W-1:0]        cur_src_n;
  logic [DIGIT_DATA_W-1:0] hex_data_n;
  logic                    active_n;
  logic                    switched_n;

  logic [DIGIT_DATA_W-1:0] src_word [NUM_SRC];
  logic                    owner_valid;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_exclude;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_word[g] = src_data[DIGIT_DATA_W*g +: DIGIT_DATA_W];
  end

  assign owner_valid  = src_valid[cur_src];
  assign pick_exclude = (state == SHOW) && !owner_valid;

  hex_rr_pick #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .valid         (src_valid),
    .start         (cur_src),
    .exclude_start (pick_exclude),
    .found         (pick_found),
    .index         (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      cur_src   <= '0;
      hex_data  <= '0;
      active    <= 1'b0;
      switched  <= 1'b0;
    end else begin
      state     <= state_n;
      dwell_cnt <= dwell_cnt_n;
      cur_src   <= cur_src_n;
      hex_data  <= hex_data_n;
      active    <= active_n;
      switched  <= switched_n;
    end
  end

  // Priority in SHOW: owner dropping valid, then advance/expiry, then plain countdown.
  always_comb begin
    state_n     = state;
    dwell_cnt_n = dwell_cnt;
    cur_src_n   = cur_src;
    hex_data_n  = hex_data;
    active_n    = active;
    switched_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n     = SHOW;
          cur_src_n   = pick_idx;
          dwell_cnt_n = RELOAD;
          active_n    = 1'b1;
          switched_n  = 1'b1;
          hex_data_n  = src_word[pick_idx];
        end
      end

      SHOW: begin
        if (!owner_valid) begin
          if (pick_found) begin
            cur_src_n   = pick_idx;
            dwell_cnt_n = RELOAD;
            switched_n  = 1'b1;
            hex_data_n  = src_word[pick_idx];
          end else begin
            state_n  = IDLE;
            active_n = 1'b0;
          end
        end else begin
          if (advance || (dwell_cnt == '0 && !freeze)) begin
            dwell_cnt_n = RELOAD;
            if (pick_found && pick_idx != cur_src) begin
              cur_src_n  = pick_idx;
              switched_n = 1'b1;
            end
          end else if (!freeze && dwell_cnt != '0) begin
            dwell_cnt_n = dwell_cnt - 1'b1;
          end
          hex_data_n = src_word[cur_src_n];
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed self-checking bench for hex_display_scheduler with NUM_SRC=4, DWELL_CYCLES=4.
module tb_hex_display_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic         advance;
  logic         freeze;
  logic [31:0]  hex_data;
  logic [1:0]   cur_src;
  logic         active;
  logic         switched;

  int compared = 0;
  int failed   = 0;

  hex_display_scheduler #(
    .NUM_SRC      (4),
    .DWELL_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .advance   (advance),
    .freeze    (freeze),
    .hex_data  (hex_data),
    .cur_src   (cur_src),
    .active    (active),
    .switched  (switched)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic adv, input logic frz);
    src_valid = valid;
    advance   = adv;
    freeze    = frz;
  endtask

  task automatic setData(input int idx, input logic [31:0] value);
    src_data[32*idx +: 32] = value;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin : stimulus
    logic [1:0] seq_cur [12];
    int pulses;

    seq_cur = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};

    rst      = 1'b1;
    src_data = '0;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_active", 32'(active), 32'd0);
    checkOutput("reset_hex", hex_data, 32'd0);
    checkOutput("reset_cur", 32'(cur_src), 32'd0);
    checkOutput("reset_switched", 32'(switched), 32'd0);

    rst = 1'b0;
    tick();
    checkOutput("idle_active", 32'(active), 32'd0);

    // First grant from IDLE
    setData(0, 32'h12345678);
    setData(1, 32'hAAAA0001);
    setData(2, 32'hBBBB0002);
    setData(3, 32'hCCCC0003);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick();
    checkOutput("grant_active", 32'(active), 32'd1);
    checkOutput("grant_cur", 32'(cur_src), 32'd0);
    checkOutput("grant_switched", 32'(switched), 32'd1);
    checkOutput("grant_hex", hex_data, 32'h12345678);

    // Round robin over 0,1,3 with four cycles each; source 2 never shown
    applyStimulus(4'b1011, 1'b0, 1'b0);
    setData(0, 32'h87654321);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("rr_cur_%0d", k), 32'(cur_src), 32'(seq_cur[k-1]));
      checkOutput($sformatf("rr_sw_%0d", k), 32'(switched),
                  (k == 4 || k == 8 || k == 12) ? 32'd1 : 32'd0);
      if (k == 1) checkOutput("rr_hex_live0", hex_data, 32'h87654321);
      if (k == 5) checkOutput("rr_hex_src1", hex_data, 32'hAAAA0001);
      if (k == 9) checkOutput("rr_hex_src3", hex_data, 32'hCCCC0003);
    end

    // Manual advance onto source 1, then source 1 drops mid-dwell
    applyStimulus(4'b1011, 1'b1, 1'b0);
    tick();
    checkOutput("adv_cur", 32'(cur_src), 32'd1);
    checkOutput("adv_sw", 32'(switched), 32'd1);
    applyStimulus(4'b1011, 1'b0, 1'b0);
    tick();
    checkOutput("adv_hold_cur", 32'(cur_src), 32'd1);
    checkOutput("adv_hold_sw", 32'(switched), 32'd0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    tick();
    checkOutput("drop_cur", 32'(cur_src), 32'd3);
    checkOutput("drop_sw", 32'(switched), 32'd1);
    tick();
    checkOutput("drop_hex", hex_data, 32'hCCCC0003);
    setData(3, 32'hDEAD0003);
    tick();
    checkOutput("live_hex3", hex_data, 32'hDEAD0003);

    // All sources drop: back to IDLE holding the last shown value
    setData(3, 32'h0BAD0003);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("none_active", 32'(active), 32'd0);
    checkOutput("none_hex", hex_data, 32'hDEAD0003);
    checkOutput("none_cur", 32'(cur_src), 32'd3);
    checkOutput("none_sw", 32'(switched), 32'd0);
    tick();
    checkOutput("none_hex_hold", hex_data, 32'hDEAD0003);

    // Freeze partway through a dwell, then advance through the freeze
    applyStimulus(4'b1011, 1'b0, 1'b0);
    tick();
    checkOutput("rearm_cur", 32'(cur_src), 32'd0);
    checkOutput("rearm_sw", 32'(switched), 32'd1);
    repeat (2) tick();
    applyStimulus(4'b1011, 1'b0, 1'b1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (switched) pulses++;
    end
    checkOutput("freeze_pulses", 32'(pulses), 32'd0);
    checkOutput("freeze_cur", 32'(cur_src), 32'd0);
    applyStimulus(4'b1011, 1'b1, 1'b1);
    tick();
    checkOutput("freeze_adv_cur", 32'(cur_src), 32'd1);
    checkOutput("freeze_adv_sw", 32'(switched), 32'd1);
    applyStimulus(4'b1011, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("reload_cur_%0d", k), 32'(cur_src), (k < 4) ? 32'd1 : 32'd3);
      checkOutput($sformatf("reload_sw_%0d", k), 32'(switched), (k == 4) ? 32'd1 : 32'd0);
    end

    // Advance coinciding with counter expiry steps exactly once
    repeat (3) tick();
    checkOutput("pre_wrap_cur", 32'(cur_src), 32'd3);
    tick();
    checkOutput("wrap_cur", 32'(cur_src), 32'd0);
    repeat (3) tick();
    applyStimulus(4'b1011, 1'b1, 1'b0);
    tick();
    checkOutput("adv_exp_cur", 32'(cur_src), 32'd1);
    checkOutput("adv_exp_sw", 32'(switched), 32'd1);
    applyStimulus(4'b1011, 1'b0, 1'b0);
    tick();
    checkOutput("adv_exp_once_cur", 32'(cur_src), 32'd1);
    checkOutput("adv_exp_once_sw", 32'(switched), 32'd0);

    // Sole valid source: advance and expiry leave it in place silently
    applyStimulus(4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("sole_cur", 32'(cur_src), 32'd2);
    checkOutput("sole_sw", 32'(switched), 32'd1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick();
    checkOutput("sole_adv_cur", 32'(cur_src), 32'd2);
    checkOutput("sole_adv_sw", 32'(switched), 32'd0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (switched) pulses++;
    end
    checkOutput("sole_exp_pulses", 32'(pulses), 32'd0);
    checkOutput("sole_exp_cur", 32'(cur_src), 32'd2);

    // Asynchronous reset between edges, then restart search from index 1
    applyStimulus(4'b0101, 1'b0, 1'b0);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_active", 32'(active), 32'd0);
    checkOutput("async_cur", 32'(cur_src), 32'd0);
    checkOutput("async_hex", hex_data, 32'd0);
    checkOutput("async_sw", 32'(switched), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("restart_cur", 32'(cur_src), 32'd2);
    checkOutput("restart_sw", 32'(switched), 32'd1);
    checkOutput("restart_active", 32'(active), 32'd1);
    checkOutput("restart_hex", hex_data, 32'hBBBB0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
